// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution / max-pool engine.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    OUT
  } state_t;

  // Edges from the last pixel being sampled to the first output beat.
  localparam int unsigned PIPE_LAT = 4;

  // Narrowest result width that holds a K*K sum of full-precision products.
  function automatic int unsigned min_out_width(input int unsigned in_width,
                                                input int unsigned k);
    return 2 * in_width + $clog2(k * k);
  endfunction

endpackage

// File: rtl/conv_window_buf.sv
// Line buffer of K-1 image rows plus K pixels; exposes the KxK window ending
// at the most recently sampled pixel and flags when that window is complete.
module conv_window_buf
  import conv_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 16,
  parameter int unsigned IMG_W    = 14,
  parameter int unsigned K        = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           shift_en,
  input  logic                           first,
  input  logic [IN_WIDTH-1:0]            pixel,
  output logic [K*K-1:0][IN_WIDTH-1:0]   window,
  output logic                           window_valid
);

  localparam int unsigned SR_LEN = (K - 1) * IMG_W + K;
  localparam int unsigned CW     = $clog2(IMG_W);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] KM1      = CW'(K - 1);

  logic [IN_WIDTH-1:0] sr [SR_LEN];
  logic [CW-1:0]       next_row, next_col, cur_row, cur_col;

  // Position of the pixel being sampled this cycle; a new frame restarts at (0,0).
  always_comb begin
    cur_row = first ? '0 : next_row;
    cur_col = first ? '0 : next_col;
  end

  // Raster position tracking and window-complete flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      next_row     <= '0;
      next_col     <= '0;
      window_valid <= 1'b0;
    end else begin
      window_valid <= shift_en && (cur_row >= KM1) && (cur_col >= KM1);
      if (shift_en) begin
        if (cur_col == LAST_COL) begin
          next_col <= '0;
          next_row <= cur_row + 1'b1;
        end else begin
          next_col <= cur_col + 1'b1;
          next_row <= cur_row;
        end
      end
    end
  end

  // Pixel shift register; sr[0] is the newest pixel.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      sr[0] <= pixel;
      for (int unsigned i = 1; i < SR_LEN; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  // Window tap (r,c) sits (K-1-r) rows and (K-1-c) pixels behind the newest pixel.
  always_comb begin
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        window[r*K+c] = sr[(K-1-r)*IMG_W + (K-1-c)];
      end
    end
  end

endmodule

// File: rtl/conv_pool_engine.sv
// Valid-mode stride-1 KxK convolution with optional ReLU and 2x2 max-pool,
// buffering a whole frame of results and emitting them as one burst.
module conv_pool_engine
  import conv_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 36,
  parameter int unsigned IMG_W     = 14,
  parameter int unsigned K         = 3,
  parameter int unsigned SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  In_IFM,
  input  logic [IN_WIDTH-1:0]  In_Weight,
  input  logic                 pool_en,
  input  logic                 relu_en,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] Out_OFM
);

  localparam int unsigned CONV_W = IMG_W - K + 1;
  localparam int unsigned NPIX   = IMG_W * IMG_W;
  localparam int unsigned NWIN   = CONV_W * CONV_W;
  localparam int unsigned NK     = K * K;
  localparam int unsigned PROD_W = 2 * IN_WIDTH;
  localparam int unsigned PW     = $clog2(NPIX + 1);
  localparam int unsigned KW     = $clog2(NK);
  localparam int unsigned ADDR_W = $clog2(NWIN);
  localparam int unsigned RW     = $clog2(CONV_W);
  localparam int unsigned DW     = $clog2(PIPE_LAT);

  localparam logic [PW-1:0]     LAST_PIX   = PW'(NPIX - 1);
  localparam logic [PW-1:0]     NK_P       = PW'(NK);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(PIPE_LAT - 1);
  localparam logic [ADDR_W-1:0] CONV_W_A   = ADDR_W'(CONV_W);
  localparam logic [RW-1:0]     LIM_FULL   = RW'(CONV_W - 1);
  localparam logic [RW-1:0]     LIM_POOL   = RW'(CONV_W / 2 - 1);

  if (OUT_WIDTH < min_out_width(IN_WIDTH, K)) begin : g_width_check
    $error("OUT_WIDTH too narrow for a full-precision K*K accumulation");
  end
  if (K < 2 || IMG_W < K) begin : g_size_check
    $error("need K >= 2 and IMG_W >= K");
  end
  if (CONV_W % 2 != 0) begin : g_pool_check
    $error("convolution output side must be even for 2x2 pooling");
  end

  state_t                      state, state_next;
  logic                        accept, start, last_pix, drain_done, out_last;
  logic [PW-1:0]               pix_cnt, pix_idx;
  logic [DW-1:0]               drain_cnt;
  logic                        pool_q, relu_q;
  logic [IN_WIDTH-1:0]         weights [NK];
  logic [NK-1:0][IN_WIDTH-1:0] window;
  logic                        window_valid;
  logic signed [PROD_W-1:0]    prod_s;
  logic [PROD_W-1:0]           prod_u;
  logic [OUT_WIDTH-1:0]        mac_sum, mac_q, relu_val;
  logic                        mac_valid;
  logic [ADDR_W-1:0]           wr_addr, rd_addr, row_a, col_a;
  logic [OUT_WIDTH-1:0]        res_buf [NWIN];
  logic [RW-1:0]               out_row, out_col, out_lim;
  logic [OUT_WIDTH-1:0]        rd_data;

  function automatic logic [OUT_WIDTH-1:0] larger(input logic [OUT_WIDTH-1:0] a,
                                                  input logic [OUT_WIDTH-1:0] b);
    if (SIGNED != 0) return ($signed(a) > $signed(b)) ? a : b;
    else             return (a > b) ? a : b;
  endfunction

  conv_window_buf #(
    .IN_WIDTH (IN_WIDTH),
    .IMG_W    (IMG_W),
    .K        (K)
  ) u_window_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .shift_en     (accept),
    .first        (start),
    .pixel        (In_IFM),
    .window       (window),
    .window_valid (window_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = LOAD;
      LOAD:    if (!in_valid) state_next = IDLE;
               else if (last_pix) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = OUT;
      OUT:     if (out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: pixels are taken only while idle or loading.
  always_comb begin
    accept    = in_valid && (state == IDLE || state == LOAD);
    start     = in_valid && (state == IDLE);
    out_valid = (state == OUT);
  end

  // Frame position flags derived from the counters.
  always_comb begin
    pix_idx    = (state == IDLE) ? '0 : pix_cnt;
    last_pix   = accept && (pix_idx == LAST_PIX);
    drain_done = (state == DRAIN) && (drain_cnt == DRAIN_LAST);
    out_lim    = pool_q ? LIM_POOL : LIM_FULL;
    out_last   = (state == OUT) && (out_row == out_lim) && (out_col == out_lim);
  end

  // Control counters, latched modes and pipeline valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt   <= '0;
      drain_cnt <= '0;
      out_row   <= '0;
      out_col   <= '0;
      pool_q    <= 1'b0;
      relu_q    <= 1'b0;
      mac_valid <= 1'b0;
      wr_addr   <= '0;
    end else begin
      if (accept) pix_cnt <= pix_idx + 1'b1;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      if (state == OUT) begin
        if (out_col == out_lim) begin
          out_col <= '0;
          out_row <= out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end else begin
        out_row <= '0;
        out_col <= '0;
      end
      if (start) begin
        pool_q <= pool_en;
        relu_q <= relu_en;
      end
      mac_valid <= window_valid;
      if (start)          wr_addr <= '0;
      else if (mac_valid) wr_addr <= wr_addr + 1'b1;
    end
  end

  // Weight capture during the first K*K pixels of a frame.
  always_ff @(posedge clk) begin
    if (accept && (pix_idx < NK_P)) weights[KW'(pix_idx)] <= In_Weight;
  end

  // Full-precision MAC over the current window.
  always_comb begin
    mac_sum = '0;
    prod_s  = '0;
    prod_u  = '0;
    for (int unsigned i = 0; i < NK; i++) begin
      if (SIGNED != 0) begin
        prod_s  = PROD_W'($signed(window[i])) * PROD_W'($signed(weights[i]));
        mac_sum = mac_sum + OUT_WIDTH'(prod_s);
      end else begin
        prod_u  = PROD_W'(window[i]) * PROD_W'(weights[i]);
        mac_sum = mac_sum + OUT_WIDTH'(prod_u);
      end
    end
  end

  // MAC result register.
  always_ff @(posedge clk) begin
    mac_q <= mac_sum;
  end

  // ReLU only has an effect on signed results.
  always_comb begin
    relu_val = ((SIGNED != 0) && relu_q && mac_q[OUT_WIDTH-1]) ? '0 : mac_q;
  end

  // Result buffer write, one entry per convolution position.
  always_ff @(posedge clk) begin
    if (mac_valid) res_buf[wr_addr] <= relu_val;
  end

  // Pooling is done on read: each pooled beat takes the max of its 2x2 block.
  always_comb begin
    row_a   = ADDR_W'(out_row);
    col_a   = ADDR_W'(out_col);
    rd_addr = '0;
    rd_data = '0;
    if (pool_q) begin
      rd_addr = (row_a << 1) * CONV_W_A + (col_a << 1);
      rd_data = larger(larger(res_buf[rd_addr], res_buf[rd_addr + 1'b1]),
                       larger(res_buf[rd_addr + CONV_W_A],
                              res_buf[rd_addr + CONV_W_A + 1'b1]));
    end else begin
      rd_addr = row_a * CONV_W_A + col_a;
      rd_data = res_buf[rd_addr];
    end
  end

  assign Out_OFM = out_valid ? rd_data : '0;

endmodule

// File: tb/tb_conv_pool_engine.sv
// Directed bench: unsigned and signed engines fed the same stimulus in lockstep.
module tb_conv_pool_engine;

  localparam int IW = 16;
  localparam int OW = 36;
  localparam int IMG = 14;
  localparam int KK = 3;
  localparam int NPIX = IMG * IMG;
  localparam int T_ONES = 0, T_RAMP = 1, T_MAX = 2, T_NEG = 3;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, pool_en, relu_en;
  logic [IW-1:0] in_ifm, in_weight;
  logic          out_valid_u, out_valid_s;
  logic [OW-1:0] ofm_u, ofm_s;
  int            n_checks = 0;
  int            n_errors = 0;

  always #5 clk = ~clk;

  conv_pool_engine #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .IMG_W(IMG), .K(KK), .SIGNED(0)
  ) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .In_IFM(in_ifm),
    .In_Weight(in_weight), .pool_en(pool_en), .relu_en(relu_en),
    .out_valid(out_valid_u), .Out_OFM(ofm_u)
  );

  conv_pool_engine #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .IMG_W(IMG), .K(KK), .SIGNED(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .In_IFM(in_ifm),
    .In_Weight(in_weight), .pool_en(pool_en), .relu_en(relu_en),
    .out_valid(out_valid_s), .Out_OFM(ofm_s)
  );

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Hand-derived results per test pattern at output beat (r,c).
  function automatic logic [OW-1:0] exp_val(input int test, input bit pool, input bit relu,
                                            input bit sgn, input int r, input int c);
    case (test)
      T_ONES:  return 36'd9;
      T_RAMP:  return pool ? OW'(14 * (2 * r + 2) + 2 * c + 2) : OW'(14 * (r + 1) + c + 1);
      T_MAX:   return sgn ? 36'd9 : 36'd38653526025;
      default: return sgn ? (relu ? 36'd0 : 36'hFFFFFFFF7) : 36'd589815;
    endcase
  endfunction

  function automatic logic [IW-1:0] pix_val(input int test, input int p);
    case (test)
      T_RAMP:  return IW'(p);
      T_MAX:   return 16'hFFFF;
      default: return 16'd1;
    endcase
  endfunction

  function automatic logic [IW-1:0] weight_val(input int test, input int p);
    if (p >= KK * KK) return IW'($urandom);
    case (test)
      T_ONES:  return 16'd1;
      T_RAMP:  return (p == 4) ? 16'd1 : 16'd0;
      default: return 16'hFFFF;
    endcase
  endfunction

  // Starts at a falling edge; mode inputs flip after the first pixel.
  task automatic drive_frame(input int test, input bit pool, input bit relu, input int npx);
    for (int p = 0; p < npx; p++) begin
      in_valid  = 1'b1;
      in_ifm    = pix_val(test, p);
      in_weight = weight_val(test, p);
      pool_en   = (p == 0) ? pool : !pool;
      relu_en   = (p == 0) ? relu : !relu;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_ifm   = '0;
  endtask

  // Called at the falling edge just after the last pixel was sampled.
  task automatic check_burst(input string label, input int test, input bit pool,
                             input bit relu, input bit junk);
    int lat  = 0;
    int nb   = pool ? 36 : 144;
    int cols = pool ? 6 : 12;
    if (junk) begin
      in_valid = 1'b1;
      in_ifm   = 16'h1234;
    end
    while (!out_valid_u && lat < 20) begin
      check({label, "_idle_vs"}, OW'(out_valid_s), '0);
      check({label, "_idle_u"}, ofm_u, '0);
      check({label, "_idle_s"}, ofm_s, '0);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({label, "_latency"}, OW'(lat), OW'(4));
    for (int b = 0; b < nb; b++) begin
      check($sformatf("%s_b%0d_vu", label, b), OW'(out_valid_u), OW'(1));
      check($sformatf("%s_b%0d_vs", label, b), OW'(out_valid_s), OW'(1));
      check($sformatf("%s_b%0d_u", label, b), ofm_u, exp_val(test, pool, relu, 1'b0, b / cols, b % cols));
      check($sformatf("%s_b%0d_s", label, b), ofm_s, exp_val(test, pool, relu, 1'b1, b / cols, b % cols));
      @(negedge clk);
    end
    check({label, "_end_vu"}, OW'(out_valid_u), '0);
    check({label, "_end_vs"}, OW'(out_valid_s), '0);
    check({label, "_end_u"}, ofm_u, '0);
    check({label, "_end_s"}, ofm_s, '0);
  endtask

  task automatic frame(input string label, input int test, input bit pool, input bit relu,
                       input int gap, input bit junk);
    repeat (gap) @(negedge clk);
    drive_frame(test, pool, relu, NPIX);
    check_burst(label, test, pool, relu, junk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bit saw;
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; in_ifm = '0; in_weight = '0;
    pool_en = 1'b0; relu_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_vu", OW'(out_valid_u), '0);
    check("reset_vs", OW'(out_valid_s), '0);
    check("reset_u", ofm_u, '0);
    check("reset_s", ofm_s, '0);
    rst_n = 1'b1;

    frame("t1_ones", T_ONES, 1'b0, 1'b0, 1, 1'b0);
    frame("t2_ramp_pool", T_RAMP, 1'b1, 1'b0, 2, 1'b0);
    frame("t3_max", T_MAX, 1'b0, 1'b0, 1, 1'b0);
    frame("t4_neg", T_NEG, 1'b0, 1'b0, 1, 1'b0);
    frame("t4_neg_relu", T_NEG, 1'b0, 1'b1, 1, 1'b0);
    frame("t4_neg_relu_pool", T_NEG, 1'b1, 1'b1, 1, 1'b0);

    // Reset mid-load at pixel 100.
    @(negedge clk);
    drive_frame(T_ONES, 1'b0, 1'b0, 100);
    in_valid = 1'b1; in_ifm = 16'd1; rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_vu", OW'(out_valid_u), '0);
    check("t5_rst_u", ofm_u, '0);
    rst_n = 1'b1; in_valid = 1'b0;
    frame("t5_after_rst", T_ONES, 1'b0, 1'b0, 2, 1'b0);

    // Back-to-back frames with alternating pooling.
    frame("t6a", T_ONES, 1'b0, 1'b0, 0, 1'b0);
    frame("t6b", T_RAMP, 1'b1, 1'b0, 0, 1'b0);
    frame("t6c", T_RAMP, 1'b0, 1'b0, 3, 1'b0);
    frame("t6d_junk", T_ONES, 1'b1, 1'b0, 0, 1'b1);

    // Short frame aborts without output.
    @(negedge clk);
    drive_frame(T_RAMP, 1'b0, 1'b0, 50);
    saw = 1'b0;
    repeat (250) begin
      @(negedge clk);
      saw |= out_valid_u | out_valid_s;
    end
    check("t7_abort_quiet", OW'(saw), '0);
    frame("t7_after_abort", T_RAMP, 1'b0, 1'b0, 0, 1'b0);

    // Reset in the middle of an output burst.
    @(negedge clk);
    drive_frame(T_ONES, 1'b0, 1'b0, NPIX);
    lat = 0;
    while (!out_valid_u && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t8_burst_started", OW'(out_valid_u), OW'(1));
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t8_rst_vu", OW'(out_valid_u), '0);
    check("t8_rst_vs", OW'(out_valid_s), '0);
    check("t8_rst_u", ofm_u, '0);
    check("t8_rst_s", ofm_s, '0);
    rst_n = 1'b1;
    frame("t8_after_rst", T_MAX, 1'b1, 1'b0, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
